// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared definitions for the up/down counter family.
//               - Run-mode encodings driven on the Mode port
//               - Control FSM state type (RUN / HALT)
// Optional    : none (COUNTER_COMPARE_EN is consumed by counter_updown_mod)
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Run-mode encodings; 2'b11 is reserved and behaves as wrap.
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    // Control FSM: HALT is entered only by a one-shot terminal count.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_next_val.sv
`default_nettype none
// ============================================================================
// Module      : counter_next_val
// Description : Combinational next-count logic for counter_updown_mod.
//               Produces the value the counter takes if it counts on the
//               next edge, plus terminal count, roll-over and halt request.
// Ports       : i_count      current count (always 0..MODULUS-1)
//               i_up         1 = count up, 0 = count down
//               i_mode       run mode (see counter_pkg)
//               o_next_count value after one count step
//               o_tc         terminal count in the current direction
//               o_roll       step rolls over (wrap mode at terminal count)
//               o_halt_req   step ends a one-shot run
// Optional    : none
// Revision    : 1.0 - initial release
// ============================================================================
module counter_next_val
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 10
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_tc,
    output logic             o_roll,
    output logic             o_halt_req
);

    // MODULUS-1 is evaluated in 64-bit before truncation so that
    // MODULUS = 2**WIDTH (even WIDTH = 32) yields the all-ones top value.
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    assign o_tc = i_up ? (i_count == c_MAX) : (i_count == '0);

    // Away from the terminal count a plain +/-1 never leaves 0..MODULUS-1,
    // so no WIDTH+1 intermediate is needed.
    always_comb begin
        o_next_count = i_count;
        o_roll       = 1'b0;
        o_halt_req   = 1'b0;
        if (!o_tc) begin
            o_next_count = i_up ? (i_count + c_ONE) : (i_count - c_ONE);
        end else begin
            case (i_mode)
                MODE_SAT: begin
                    o_next_count = i_count;
                end
                MODE_ONESHOT: begin
                    o_next_count = i_count;
                    o_halt_req   = 1'b1;
                end
                default: begin
                    // Wrap mode and the reserved encoding.
                    o_next_count = i_up ? '0 : c_MAX;
                    o_roll       = 1'b1;
                end
            endcase
        end
    end

endmodule : counter_next_val
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_mod
// Description : Parametrised up/down modulo counter with wrap, saturate and
//               one-shot run modes, terminal-count and wrap flags for
//               cascading. All state changes on the falling edge of Clk.
// Ports       : Clk        clock (falling-edge active)
//               Reset      synchronous active-high reset
//               Load       load Count_in (clamped to MODULUS-1)
//               Count_en   count enable
//               Up         1 = up, 0 = down
//               Mode       00 wrap, 01 saturate, 10 one-shot, 11 wrap
//               Count_in   parallel load value
//               Count_out  current count
//               Tc         combinational terminal count
//               Wrap       one-cycle pulse after a roll-over
//               Done       one-shot complete, counter halted
//               Cmp_val    compare value        (COUNTER_COMPARE_EN only)
//               Match      one-cycle match pulse (COUNTER_COMPARE_EN only)
// Optional    : define COUNTER_COMPARE_EN to add the Cmp_val/Match compare.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic             Count_en,
    input  logic             Up,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] Count_in,
    output logic [WIDTH-1:0] Count_out,
    output logic             Tc,
    output logic             Wrap,
    output logic             Done
`ifdef COUNTER_COMPARE_EN
    ,
    input  logic [WIDTH-1:0] Cmp_val,
    output logic             Match
`endif
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    state_t           r_state;

    logic [WIDTH-1:0] w_next_count;
    logic             w_tc;
    logic             w_roll;
    logic             w_halt_req;
    logic [WIDTH-1:0] w_load_val;
    logic             w_count_step;

    counter_next_val #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next_val (
        .i_count      (r_count),
        .i_up         (Up),
        .i_mode       (Mode),
        .o_next_count (w_next_count),
        .o_tc         (w_tc),
        .o_roll       (w_roll),
        .o_halt_req   (w_halt_req)
    );

    // Out-of-range loads are clamped to the top of the count range.
    assign w_load_val   = (Count_in > c_MAX) ? c_MAX : Count_in;
    assign w_count_step = Count_en && (r_state == RUN);

    always_ff @(negedge Clk) begin
        if (Reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_state <= RUN;
        end else if (Load) begin
            r_count <= w_load_val;
            r_wrap  <= 1'b0;
            r_state <= RUN;
        end else if (w_count_step) begin
            r_count <= w_next_count;
            r_wrap  <= w_roll;
            if (w_halt_req) begin
                r_state <= HALT;
            end
        end else begin
            r_wrap  <= 1'b0;
        end
    end

`ifdef COUNTER_COMPARE_EN
    logic r_match;

    // A hold (saturate/one-shot at Tc) does not "become" equal, so a
    // counting step only matches when the value actually changes.
    always_ff @(negedge Clk) begin
        if (Reset) begin
            r_match <= 1'b0;
        end else if (Load) begin
            r_match <= (w_load_val == Cmp_val);
        end else if (w_count_step) begin
            r_match <= (w_next_count != r_count) && (w_next_count == Cmp_val);
        end else begin
            r_match <= 1'b0;
        end
    end

    assign Match = r_match;
`endif

    assign Count_out = r_count;
    assign Tc        = w_tc;
    assign Wrap      = r_wrap;
    assign Done      = (r_state == HALT);

endmodule : counter_updown_mod
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_updown_mod
// Description : Self-checking bench for counter_updown_mod (WIDTH=4,
//               MODULUS=10): directed scenarios plus a randomized run
//               against a behavioural model of the counter.
// Optional    : compare scenarios compile in with COUNTER_COMPARE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updown_mod;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Load = 1'b0;
    logic         Count_en = 1'b0;
    logic         Up = 1'b1;
    logic [1:0]   Mode = 2'b00;
    logic [W-1:0] Count_in = '0;
    logic [W-1:0] Count_out;
    logic         Tc;
    logic         Wrap;
    logic         Done;
`ifdef COUNTER_COMPARE_EN
    logic [W-1:0] Cmp_val = '0;
    logic         Match;
`endif

    int passed = 0;
    int total  = 0;

    // Behavioural model state.
    int m_cnt   = 0;
    bit m_wrap  = 0;
    bit m_done  = 0;
    bit m_match = 0;
    int m_cmp   = 0;

    counter_updown_mod #(
        .WIDTH   (W),
        .MODULUS (MOD)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .Count_en  (Count_en),
        .Up        (Up),
        .Mode      (Mode),
        .Count_in  (Count_in),
        .Count_out (Count_out),
        .Tc        (Tc),
        .Wrap      (Wrap),
        .Done      (Done)
`ifdef COUNTER_COMPARE_EN
        ,
        .Cmp_val   (Cmp_val),
        .Match     (Match)
`endif
    );

    always #5 Clk = ~Clk;

    // Apply inputs, let one falling edge pass, then advance the model.
    task automatic tick(input bit rst, input bit ld, input bit en, input bit up,
                        input logic [1:0] md, input int cin);
        int prev;
        Reset    = rst;
        Load     = ld;
        Count_en = en;
        Up       = up;
        Mode     = md;
        Count_in = W'(cin);
        @(negedge Clk);
        #1;
        prev    = m_cnt;
        m_wrap  = 0;
        m_match = 0;
        if (rst) begin
            m_cnt  = 0;
            m_done = 0;
        end else if (ld) begin
            m_cnt   = (cin >= MOD) ? MOD - 1 : cin;
            m_done  = 0;
            m_match = (m_cnt == m_cmp);
        end else if (en && !m_done) begin
            if (up && m_cnt < MOD - 1)      m_cnt = m_cnt + 1;
            else if (!up && m_cnt > 0)      m_cnt = m_cnt - 1;
            else if (md == 2'b01)           m_cnt = m_cnt;
            else if (md == 2'b10)           m_done = 1;
            else begin
                m_cnt  = up ? 0 : MOD - 1;
                m_wrap = 1;
            end
            m_match = (m_cnt != prev) && (m_cnt == m_cmp);
        end
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 1, 2'b00, 0);
        total++; if (Count_out !== 4'd0) $display("FAIL reset_count: got %0d expected 0", Count_out); else passed++;
        total++; if (Wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", Wrap); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Done); else passed++;
    endtask

    task automatic test_wrap_up();
        int wraps;
        int exp;
        wraps = 0;
        tick(1, 0, 0, 1, 2'b00, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 1, 1, 2'b00, 0);
            exp = (i + 1) % MOD;
            total++; if (Count_out !== W'(exp)) $display("FAIL wrap_up_count[%0d]: got %0d expected %0d", i, Count_out, exp); else passed++;
            total++; if (Wrap !== (i == 9)) $display("FAIL wrap_up_flag[%0d]: got %b expected %b", i, Wrap, (i == 9)); else passed++;
            total++; if (Tc !== (exp == 9)) $display("FAIL wrap_up_tc[%0d]: got %b expected %b", i, Tc, (exp == 9)); else passed++;
            if (Wrap === 1'b1) wraps++;
        end
        total++; if (wraps !== 1) $display("FAIL wrap_up_pulses: got %0d expected 1", wraps); else passed++;
    endtask

    task automatic test_down_and_sat();
        tick(1, 0, 0, 0, 2'b00, 0);
        tick(0, 0, 1, 0, 2'b00, 0);
        total++; if (Count_out !== 4'd9) $display("FAIL wrap_down_count: got %0d expected 9", Count_out); else passed++;
        total++; if (Wrap !== 1'b1) $display("FAIL wrap_down_flag: got %b expected 1", Wrap); else passed++;
        tick(1, 0, 0, 0, 2'b01, 0);
        tick(0, 0, 1, 0, 2'b01, 0);
        total++; if (Count_out !== 4'd0) $display("FAIL sat_down_count: got %0d expected 0", Count_out); else passed++;
        total++; if (Wrap !== 1'b0) $display("FAIL sat_down_wrap: got %b expected 0", Wrap); else passed++;
        total++; if (Tc !== 1'b1) $display("FAIL sat_down_tc: got %b expected 1", Tc); else passed++;
    endtask

    task automatic test_oneshot();
        int e_cnt [4] = '{8, 9, 9, 9};
        bit e_done[4] = '{0, 0, 1, 1};
        tick(1, 0, 0, 1, 2'b10, 0);
        tick(0, 1, 0, 1, 2'b10, 7);
        total++; if (Count_out !== 4'd7) $display("FAIL oneshot_load: got %0d expected 7", Count_out); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 1, 2'b10, 0);
            total++; if (Count_out !== W'(e_cnt[i])) $display("FAIL oneshot_count[%0d]: got %0d expected %0d", i, Count_out, e_cnt[i]); else passed++;
            total++; if (Done !== e_done[i]) $display("FAIL oneshot_done[%0d]: got %b expected %b", i, Done, e_done[i]); else passed++;
            total++; if (Wrap !== 1'b0) $display("FAIL oneshot_wrap[%0d]: got %b expected 0", i, Wrap); else passed++;
        end
        total++; if (Tc !== 1'b1) $display("FAIL halt_tc: got %b expected 1", Tc); else passed++;
        // Switching to wrap mode while halted must not resume counting.
        tick(0, 0, 1, 1, 2'b00, 0);
        total++; if (Count_out !== 4'd9) $display("FAIL halt_mode_change_count: got %0d expected 9", Count_out); else passed++;
        total++; if (Done !== 1'b1) $display("FAIL halt_mode_change_done: got %b expected 1", Done); else passed++;
        total++; if (Wrap !== 1'b0) $display("FAIL halt_mode_change_wrap: got %b expected 0", Wrap); else passed++;
        tick(0, 1, 1, 1, 2'b10, 3);
        total++; if (Count_out !== 4'd3) $display("FAIL halt_reload_count: got %0d expected 3", Count_out); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL halt_reload_done: got %b expected 0", Done); else passed++;
        tick(0, 0, 1, 1, 2'b10, 0);
        total++; if (Count_out !== 4'd4) $display("FAIL oneshot_resume: got %0d expected 4", Count_out); else passed++;
    endtask

    task automatic test_load();
        tick(0, 1, 0, 1, 2'b00, 14);
        total++; if (Count_out !== 4'd9) $display("FAIL load_clamp_14: got %0d expected 9", Count_out); else passed++;
        tick(0, 1, 0, 1, 2'b00, 10);
        total++; if (Count_out !== 4'd9) $display("FAIL load_clamp_10: got %0d expected 9", Count_out); else passed++;
        tick(0, 1, 1, 1, 2'b00, 2);
        total++; if (Count_out !== 4'd2) $display("FAIL load_beats_count: got %0d expected 2", Count_out); else passed++;
        tick(0, 1, 0, 0, 2'b00, 0);
        total++; if (Tc !== 1'b1) $display("FAIL load_zero_down_tc: got %b expected 1", Tc); else passed++;
    endtask

    task automatic test_reset_override();
        tick(1, 0, 0, 1, 2'b00, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 1, 2'b00, 0);
        total++; if (Count_out !== 4'd5) $display("FAIL pre_reset_count: got %0d expected 5", Count_out); else passed++;
        tick(1, 0, 1, 1, 2'b00, 0);
        total++; if (Count_out !== 4'd0) $display("FAIL reset_mid_count: got %0d expected 0", Count_out); else passed++;
        tick(0, 1, 0, 1, 2'b10, 9);
        tick(0, 0, 1, 1, 2'b10, 0);
        total++; if (Done !== 1'b1) $display("FAIL pre_reset_halt: got %b expected 1", Done); else passed++;
        tick(1, 0, 1, 1, 2'b10, 0);
        total++; if (Count_out !== 4'd0) $display("FAIL reset_in_halt_count: got %0d expected 0", Count_out); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL reset_in_halt_done: got %b expected 0", Done); else passed++;
        total++; if (Wrap !== 1'b0) $display("FAIL reset_in_halt_wrap: got %b expected 0", Wrap); else passed++;
        for (int i = 0; i < 2; i++) begin
            tick(1, 1, 1, 1, 2'b00, 7);
            total++; if (Count_out !== 4'd0) $display("FAIL reset_with_load[%0d]: got %0d expected 0", i, Count_out); else passed++;
        end
    endtask

`ifdef COUNTER_COMPARE_EN
    task automatic test_compare();
        m_cmp   = 6;
        Cmp_val = 4'd6;
        tick(1, 0, 0, 1, 2'b00, 0);
        total++; if (Match !== 1'b0) $display("FAIL match_reset: got %b expected 0", Match); else passed++;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 1, 1, 2'b00, 0);
            total++; if (Match !== (i == 5)) $display("FAIL match_count[%0d]: got %b expected %b", i, Match, (i == 5)); else passed++;
        end
        tick(0, 1, 0, 1, 2'b00, 6);
        total++; if (Match !== 1'b1) $display("FAIL match_load: got %b expected 1", Match); else passed++;
        tick(0, 0, 0, 1, 2'b00, 0);
        total++; if (Match !== 1'b0) $display("FAIL match_load_pulse: got %b expected 0", Match); else passed++;
    endtask
`endif

    task automatic test_random();
        bit exp_tc;
        m_cmp = $urandom_range(0, MOD - 1);
`ifdef COUNTER_COMPARE_EN
        Cmp_val = W'(m_cmp);
`endif
        for (int i = 0; i < 500; i++) begin
            tick(($urandom % 32) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                 1'($urandom % 2), 2'($urandom % 4), int'($urandom % 16));
            exp_tc = Up ? (m_cnt == MOD - 1) : (m_cnt == 0);
            total++; if (Count_out !== W'(m_cnt)) $display("FAIL rand_count[%0d]: got %0d expected %0d", i, Count_out, m_cnt); else passed++;
            total++; if (Wrap !== m_wrap) $display("FAIL rand_wrap[%0d]: got %b expected %b", i, Wrap, m_wrap); else passed++;
            total++; if (Done !== m_done) $display("FAIL rand_done[%0d]: got %b expected %b", i, Done, m_done); else passed++;
            total++; if (Tc !== exp_tc) $display("FAIL rand_tc[%0d]: got %b expected %b", i, Tc, exp_tc); else passed++;
`ifdef COUNTER_COMPARE_EN
            total++; if (Match !== m_match) $display("FAIL rand_match[%0d]: got %b expected %b", i, Match, m_match); else passed++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_and_sat();
        test_oneshot();
        test_load();
        test_reset_override();
`ifdef COUNTER_COMPARE_EN
        test_compare();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_counter_updown_mod
`default_nettype wire

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised up/down counter, the next generation of the team's 4-bit counter. Width and modulus are configurable. Three run modes are selectable at run time: wrap, saturate and one-shot. Terminal-count and wrap flags allow cascading. Used as the general-purpose counter in timer, divider and sequencing datapaths.

Parameters:
WIDTH, 4, counter width in bits (2..32)
MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH

Ports:
Clk  input  1  clock; all state updates on falling edge
Reset  input  1  synchronous, active-high reset
Load  input  1  load Count_in (highest priority after Reset)
Count_en  input  1  count enable
Up  input  1  1 = count up, 0 = count down
Mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap)
Count_in  input  WIDTH  parallel load value
Count_out  output  WIDTH  current count
Tc  output  1  combinational terminal count: (Up & Count_out==MODULUS-1) | (~Up & Count_out==0)
Wrap  output  1  registered one-cycle pulse: counter rolled over on the previous edge
Done  output  1  one-shot complete; counter halted

Behaviour:
- One clock, Clk falling edge. Reset is synchronous, active-high; no asynchronous paths.
- Reset: Count_out=0, Wrap=0, Done=0, FSM=RUN. Reset mid-count or mid-halt takes effect on the next edge and overrides every other input.
- Priority per edge: Reset > Load > count > hold.
- Load: Count_out <= Count_in, clamped to MODULUS-1 if Count_in >= MODULUS. Also clears Done and returns FSM to RUN. Wrap=0.
- Count (Count_en=1, FSM=RUN, no Load):
  - Up, not at Tc: +1. Down, not at Tc: -1. Arithmetic is WIDTH bits; no intermediate overflow is permitted.
  - Wrap mode at Tc: up goes to 0, down goes to MODULUS-1; Wrap=1 for one cycle.
  - Saturate mode at Tc: hold value; Wrap=0.
  - One-shot mode at Tc: hold value; FSM goes to HALT; Done=1; Wrap=0.
- Hold: Count_en=0 keeps value, Wrap=0. Mode and Up changes take effect immediately for next-value and Tc computation.
- FSM states:
  - RUN: normal operation.
  - HALT: counting ignored even if Count_en=1. Exits only via Load (to RUN) or Reset (to RUN).
  - Changing Mode while in HALT does not exit HALT.
- Wrap is low in every cycle that did not roll over. It is never asserted in saturate or one-shot modes.
- Tc is valid in every state, including HALT. For cascading, the downstream Count_en = upstream Count_en & Tc.
- MODULUS = 2**WIDTH reduces to a plain binary counter; the compare against MODULUS-1 must still synthesize correctly.

Optional Feature:
Macro COUNTER_COMPARE_EN.
- Defined: adds input Cmp_val (WIDTH) and output Match. Match is registered and asserts for one cycle after the edge on which Count_out becomes equal to Cmp_val by counting or loading. Match=0 on reset.
- Undefined: neither port exists; no compare logic.

Decomposition:
- Package counter_pkg holds:
  - mode encoding constants: MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10
  - FSM state typedef {RUN, HALT}
- Sub-module counter_next_val (combinational) computes next count, Tc and roll-over from current count, Up, Mode and MODULUS. The top level holds the registers, FSM, Load clamp and optional compare.

Test Plan:
- WIDTH=4, MODULUS=10, wrap mode, Up=1, Count_en=1 from reset, 12 edges -> counts 1..9, 0, 1, 2; Wrap pulses exactly once (after 9->0); Tc high while Count_out=9.
- Wrap mode, Up=0 from 0 -> next edge gives 9 with Wrap=1; saturate mode, Up=0 at 0 -> stays 0, Wrap=0.
- One-shot, Load 7 then count up 4 edges -> 8, 9, 9, 9; Done=1 after reaching 9; Count_en kept high leaves count at 9; Load 3 -> Count_out=3, Done=0, counting resumes.
- Load Count_in=4'hE with MODULUS=10 -> Count_out=9; Load and Count_en together -> load wins.
- Reset asserted while counting at 5, and again in HALT -> next edge Count_out=0, Done=0, Wrap=0; Reset held with Load=1 -> stays 0.
- COUNTER_COMPARE_EN, Cmp_val=6, count up from 0 -> Match high exactly one cycle after Count_out becomes 6; Load 6 -> Match pulses once.
